// File: rtl/rxll_drain_ctrl_if.sv
// DMA write-burst port of the receive FIFO drain controller: a req/ack burst
// grant followed by valid/ready data beats.
interface rxll_drain_ctrl_if;
    logic        dma_req;
    logic [4:0]  dma_len;
    logic        dma_ack;
    logic        dma_valid;
    logic        dma_ready;
    logic [31:0] dma_data;
    logic        dma_last;
    logic        dma_eof;

    // A beat transfers on every rising edge where dma_valid && dma_ready are both high;
    // while dma_valid && !dma_ready, dma_data/dma_last/dma_eof hold their values.
    modport master (
        output dma_req, dma_len, dma_valid, dma_data, dma_last, dma_eof,
        input  dma_ack, dma_ready
    );
    modport slave (
        input  dma_req, dma_len, dma_valid, dma_data, dma_last, dma_eof,
        output dma_ack, dma_ready
    );
endinterface

// File: rtl/rxll_drain_ctrl.sv
// Receive FIFO drain controller: decides when to start DMA bursts, streams FIFO
// words out, enforces frame boundaries and max length, and reports frame status.
module rxll_drain_ctrl #(
    parameter int C_BURST_WORDS     = 16,
    parameter int C_MAX_FRAME_WORDS = 2049
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [35:0]              fifo_rd_do,
    input  logic                     fifo_rd_empty,
    input  logic [9:0]               fifo_rd_count,
    input  logic                     fifo_rd_eof_rdy,
    output logic                     fifo_rd_en,
    rxll_drain_ctrl_if.master        dma,
    output logic                     frm_busy,
    output logic                     frm_done,
    output logic [11:0]              frm_len,
    output logic                     frm_err,
    output logic [2:0]               state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [11:0] MAX_W   = 12'(C_MAX_FRAME_WORDS);
    localparam logic [11:0] BURST_W = 12'(C_BURST_WORDS);

    state_t      state_q, state_d;
    logic [11:0] frm_cnt_q, frm_cnt_d;
    logic [4:0]  beat_cnt_q, beat_cnt_d;
    logic [4:0]  len_q, len_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [11:0] rem, cnt_ext, avail;
    logic        head_sof, head_err, head_eof;
    logic        beat_last, beat_take;

    assign head_sof = fifo_rd_do[32];
    assign head_err = fifo_rd_do[33];
    assign head_eof = fifo_rd_do[34];

    // avail never exceeds the reported count, so a lagging count only delays bursts.
    always_comb begin
        rem     = MAX_W - frm_cnt_q;
        cnt_ext = {2'b00, fifo_rd_count};
        avail   = cnt_ext;
        if (BURST_W < avail) avail = BURST_W;
        if (rem < avail)     avail = rem;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            frm_cnt_q  <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frm_cnt_q  <= frm_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frm_cnt_d     = frm_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        len_d         = len_q;
        err_d         = err_q;
        busy_d        = busy_q;
        beat_last     = 1'b0;
        beat_take     = 1'b0;
        fifo_rd_en    = 1'b0;
        dma.dma_req   = 1'b0;
        dma.dma_len   = len_q;
        dma.dma_valid = 1'b0;
        dma.dma_data  = '0;
        dma.dma_last  = 1'b0;
        dma.dma_eof   = 1'b0;
        frm_done      = 1'b0;
        frm_len       = '0;
        frm_err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_rd_empty) begin
                    if (!busy_q && !head_sof) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else if (busy_q && rem == 12'd0) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else if (avail != 12'd0 &&
                                 (cnt_ext >= BURST_W || fifo_rd_eof_rdy || avail == rem)) begin
                        len_d      = avail[4:0];
                        beat_cnt_d = avail[4:0];
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                dma.dma_req = 1'b1;
                if (dma.dma_ack) state_d = S_XFER;
            end
            S_XFER: begin
                beat_last     = (beat_cnt_q == 5'd1) || head_eof;
                beat_take     = !fifo_rd_empty && dma.dma_ready;
                dma.dma_valid = !fifo_rd_empty;
                dma.dma_data  = fifo_rd_do[31:0];
                dma.dma_eof   = head_eof;
                dma.dma_last  = beat_last;
                fifo_rd_en    = beat_take;
                if (beat_take) begin
                    frm_cnt_d  = frm_cnt_q + 12'd1;
                    beat_cnt_d = beat_cnt_q - 5'd1;
                    err_d      = err_q | head_err;
                    if (head_sof) busy_d = 1'b1;
                    if (beat_last) state_d = head_eof ? S_DONE : S_IDLE;
                end
            end
            S_DRAIN: begin
                fifo_rd_en = !fifo_rd_empty;
                if (!fifo_rd_empty && head_eof) state_d = S_DONE;
            end
            S_DONE: begin
                frm_done  = 1'b1;
                frm_len   = frm_cnt_q;
                frm_err   = err_q;
                frm_cnt_d = '0;
                err_d     = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frm_busy  = busy_q;
    assign state_dbg = state_q;
endmodule
